// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared widths and grant encoding for the register-file write arbiter
package reg_write_arbiter_pkg;
  localparam int N_DEF = 16;
  localparam int M_DEF = 3;
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_e;
endpackage

// File: rtl/reg_write_arbiter_rf_scoreboard.sv
// rf_scoreboard: pending-write bit per register with set-wins-over-clear and sticky WAW detection
module rf_scoreboard
  import reg_write_arbiter_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            set_en,
  input  logic [M-1:0]    set_ad,
  input  logic            clr_en,
  input  logic [M-1:0]    clr_ad,
  input  logic [M-1:0]    chk_ad_1,
  input  logic [M-1:0]    chk_ad_2,
  output logic            hazard_1,
  output logic            hazard_2,
  output logic [2**M-1:0] pending,
  output logic            waw_err
);
  localparam int R = 2**M;
  logic [R-1:0] set_mask, clr_mask;
  logic         waw_hit;
  always_comb begin
    set_mask = set_en ? R'(1) << set_ad : '0;
    clr_mask = clr_en ? R'(1) << clr_ad : '0;
    waw_hit  = set_en && pending[set_ad] && !(clr_en && clr_ad == set_ad);
    hazard_1 = pending[chk_ad_1];
    hazard_2 = pending[chk_ad_2];
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pending <= '0;
      waw_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      waw_err <= waw_err | waw_hit;
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin ALU/load arbitration onto the single register-file write port
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [M-1:0]    alu_ad,
  input  logic [N-1:0]    alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [M-1:0]    ld_ad,
  input  logic [N-1:0]    ld_data,
  output logic            Reg_Write,
  output logic [M-1:0]    Reg_write_ad,
  output logic [N-1:0]    Reg_write_data,
  input  logic            iss_valid,
  input  logic [M-1:0]    iss_ad,
  input  logic [M-1:0]    chk_ad_1,
  input  logic [M-1:0]    chk_ad_2,
  output logic            hazard_1,
  output logic            hazard_2,
  output logic [2**M-1:0] pending,
  output logic            waw_err
);
  req_e last_grant;
  logic accept;
  // a lone requester always wins; on a tie the side that did not win last goes
  always_comb begin
    alu_ready = Reset && alu_valid && (!ld_valid || last_grant == REQ_LD);
    ld_ready  = Reset && ld_valid && (!alu_valid || last_grant == REQ_ALU);
    accept    = alu_ready || ld_ready;
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      last_grant     <= REQ_LD;
      Reg_Write      <= 1'b0;
      Reg_write_ad   <= '0;
      Reg_write_data <= '0;
    end else begin
      Reg_Write <= accept;
      if (accept) begin
        last_grant     <= ld_ready ? REQ_LD : REQ_ALU;
        Reg_write_ad   <= ld_ready ? ld_ad : alu_ad;
        Reg_write_data <= ld_ready ? ld_data : alu_data;
      end
    end
  end
  rf_scoreboard #(.M(M)) u_sb (
    .Clock    (Clock),
    .Reset    (Reset),
    .set_en   (iss_valid),
    .set_ad   (iss_ad),
    .clr_en   (Reg_Write),
    .clr_ad   (Reg_write_ad),
    .chk_ad_1 (chk_ad_1),
    .chk_ad_2 (chk_ad_2),
    .hazard_1 (hazard_1),
    .hazard_2 (hazard_2),
    .pending  (pending),
    .waw_err  (waw_err)
  );
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_reg_write_arbiter;
  localparam int N = 16, M = 3, R = 8;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic alu_valid = 0, ld_valid = 0, iss_valid = 0;
  logic [M-1:0] alu_ad = 0, ld_ad = 0, iss_ad = 0, chk_ad_1 = 0, chk_ad_2 = 0;
  logic [N-1:0] alu_data = 0, ld_data = 0;
  logic alu_ready, ld_ready, Reg_Write, hazard_1, hazard_2, waw_err;
  logic [M-1:0] Reg_write_ad;
  logic [N-1:0] Reg_write_data;
  logic [R-1:0] pending;
  int total = 0, bad = 0;
  int m_last;
  bit m_wr, m_waw;
  bit [M-1:0] m_wad;
  bit [N-1:0] m_wdata;
  bit m_pend[R];

  reg_write_arbiter #(.N(N), .M(M)) dut (
    .Clock(clk), .Reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_ad(alu_ad), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ad(ld_ad), .ld_data(ld_data),
    .Reg_Write(Reg_Write), .Reg_write_ad(Reg_write_ad), .Reg_write_data(Reg_write_data),
    .iss_valid(iss_valid), .iss_ad(iss_ad), .chk_ad_1(chk_ad_1), .chk_ad_2(chk_ad_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .pending(pending), .waw_err(waw_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = 0;
    for (int i = 0; i < R; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // one clock: combinational checks, model update at the edge, registered checks after
  task automatic step(output bit ga, output bit gl);
    ga = reset && alu_valid && (!ld_valid || m_last == 1);
    gl = reset && ld_valid && (!alu_valid || m_last == 0);
    #1;
    check("alu_ready", alu_ready, ga);
    check("ld_ready", ld_ready, gl);
    check("hazard_1", hazard_1, m_pend[chk_ad_1]);
    check("hazard_2", hazard_2, m_pend[chk_ad_2]);
    @(posedge clk);
    if (!reset) begin
      m_last = 1; m_wr = 0; m_wad = 0; m_wdata = 0; m_waw = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (iss_valid && m_pend[iss_ad] && !(m_wr && m_wad == iss_ad)) m_waw = 1;
      if (m_wr) m_pend[m_wad] = 0;
      if (iss_valid) m_pend[iss_ad] = 1;
      m_wr = ga || gl;
      if (ga) begin m_wad = alu_ad; m_wdata = alu_data; m_last = 0; end
      else if (gl) begin m_wad = ld_ad; m_wdata = ld_data; m_last = 1; end
    end
    @(negedge clk);
    check("Reg_Write", Reg_Write, m_wr);
    check("Reg_write_ad", Reg_write_ad, m_wad);
    check("Reg_write_data", Reg_write_data, m_wdata);
    check("pending", pending, pend_vec());
    check("waw_err", waw_err, m_waw);
  endtask

  initial begin
    bit ga, gl;
    m_last = 1; m_wr = 0; m_wad = 0; m_wdata = 0; m_waw = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    @(negedge clk);
    alu_valid = 1;
    step(ga, gl);
    step(ga, gl);
    check("t1_ready", alu_ready, 0);
    reset = 1; alu_valid = 1; alu_ad = 0; alu_data = 20;
    step(ga, gl);
    check("t2_we", Reg_Write, 1);
    check("t2_ad", Reg_write_ad, 0);
    check("t2_data", Reg_write_data, 20);
    alu_valid = 0;
    step(ga, gl);
    check("t2_idle", Reg_Write, 0);
    reset = 0;
    step(ga, gl);
    reset = 1; alu_valid = 1; alu_ad = 1; alu_data = 10; ld_valid = 1; ld_ad = 5; ld_data = 30;
    for (int i = 0; i < 4; i++) begin
      step(ga, gl);
      check("t3_order", alu_ready === 1'bx ? 2 : Reg_write_data, (i % 2) ? 30 : 10);
      check("t3_we", Reg_Write, 1);
    end
    alu_valid = 0; ld_valid = 0;
    step(ga, gl);
    iss_valid = 1; iss_ad = 5; chk_ad_1 = 5;
    step(ga, gl);
    iss_valid = 0;
    check("t4_haz_set", hazard_1, 1);
    ld_valid = 1; ld_ad = 5; ld_data = 7;
    step(ga, gl);
    ld_valid = 0;
    check("t4_haz_during_write", hazard_1, 1);
    step(ga, gl);
    check("t4_haz_clear", hazard_1, 0);
    iss_valid = 1; iss_ad = 3;
    step(ga, gl);
    iss_valid = 0; alu_valid = 1; alu_ad = 3; alu_data = 9;
    step(ga, gl);
    alu_valid = 0; iss_valid = 1; iss_ad = 3;
    step(ga, gl);
    check("t5_pend3", pending[3], 1);
    check("t5_no_waw", waw_err, 0);
    step(ga, gl);
    iss_valid = 0;
    check("t5_waw", waw_err, 1);
    alu_valid = 1; alu_ad = 2; alu_data = 4;
    step(ga, gl);
    alu_valid = 0; reset = 0;
    step(ga, gl);
    check("t6_we", Reg_Write, 0);
    check("t6_pend", pending, 0);
    reset = 1; alu_valid = 1; ld_valid = 1;
    step(ga, gl);
    check("t6_alu_wins", ga, 1);
    for (int c = 0; c < 500; c++) begin
      if (!(alu_valid && !ga)) begin
        alu_valid = $urandom_range(0, 1); alu_ad = $urandom; alu_data = $urandom;
      end
      if (!(ld_valid && !gl)) begin
        ld_valid = $urandom_range(0, 1); ld_ad = $urandom; ld_data = $urandom;
      end
      iss_valid = $urandom_range(0, 2) == 0; iss_ad = $urandom;
      chk_ad_1 = $urandom; chk_ad_2 = $urandom;
      reset = $urandom_range(0, 39) != 0;
      step(ga, gl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
